// File: rtl/isp1761_pkg.sv
// Shared types and widths for the ISP1761 bus sequencer: access and
// init state encodings plus the bus address/data widths.
package isp1761_pkg;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ACC_IDLE,
        ACC_SETUP,
        ACC_STROBE,
        ACC_HOLD,
        ACC_RECOVER
    } acc_state_t;

    typedef enum logic [1:0] {
        INIT_RST_LOW,
        INIT_RST_WAIT,
        INIT_READY
    } init_state_t;
endpackage

// File: rtl/isp1761_bus_sequencer_if.sv
// Command/response handshake and s_* bus signals of the ISP1761 sequencer.
// master = the sequencer itself, slave = upstream logic plus the bus.
interface isp1761_bus_sequencer_if
    import isp1761_pkg::*;
    ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              s_cs_n;
    logic              s_read_n;
    logic              s_write_n;
    logic [ADDR_W-1:0] s_address;
    logic [DATA_W-1:0] s_writedata;
    logic [DATA_W-1:0] s_readdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, s_readdata,
        output cmd_ready, rsp_valid, rsp_rdata,
        output s_cs_n, s_read_n, s_write_n, s_address, s_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, s_readdata,
        input  cmd_ready, rsp_valid, rsp_rdata,
        input  s_cs_n, s_read_n, s_write_n, s_address, s_writedata
    );
endinterface

// File: rtl/isp1761_irq_sync.sv
// Two-flop synchroniser for the controller interrupt plus a registered
// rising-edge pulse on the synchronised level.
module isp1761_irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_async,
    output logic irq_level,
    output logic irq_pulse
);
    logic sync_1;
    logic sync_2;
    logic level_d;
    logic pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level_d <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_1  <= irq_async;
            sync_2  <= sync_1;
            level_d <= sync_2;
            pulse_q <= sync_2 & ~level_d;
        end
    end

    assign irq_level = sync_2;
    assign irq_pulse = pulse_q;
endmodule

// File: rtl/isp1761_bus_sequencer.sv
// Single-beat read/write engine for the ISP1761 s_* bus with controller
// power-on reset sequencing and interrupt synchronisation.
module isp1761_bus_sequencer
    import isp1761_pkg::*;
#(
    parameter int SETUP_CYC    = 2,
    parameter int STROBE_CYC   = 3,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 2,
    parameter int RST_LOW_CYC  = 1000,
    parameter int RST_WAIT_CYC = 5000
) (
    input  logic                      s_clk,
    input  logic                      s_reset_n,
    isp1761_bus_sequencer_if.master   bus,
    input  logic                      s_irq,
    output logic                      irq_level,
    output logic                      irq_pulse,
    output logic                      usb_reset_n
);
    localparam logic [3:0]  SETUP_LD    = 4'(SETUP_CYC - 1);
    localparam logic [3:0]  STROBE_LD   = 4'(STROBE_CYC - 1);
    localparam logic [3:0]  HOLD_LD     = 4'(HOLD_CYC - 1);
    localparam logic [3:0]  RECOVER_LD  = 4'(RECOVERY_CYC - 1);
    localparam logic [15:0] RST_LOW_LD  = 16'(RST_LOW_CYC - 1);
    localparam logic [15:0] RST_WAIT_LD = 16'(RST_WAIT_CYC - 1);

    acc_state_t        acc_state;
    init_state_t       init_state;
    logic [3:0]        phase_cnt;
    logic [15:0]       init_cnt;
    logic              wr_q;
    logic              cs_n_q;
    logic              rd_n_q;
    logic              wr_n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              usb_rst_n_q;
    logic              cmd_ready;

    assign cmd_ready = (acc_state == ACC_IDLE) && (init_state == INIT_READY);

    // Strobes live in the async reset branch so an abort releases the bus at once.
    always_ff @(posedge s_clk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            acc_state   <= ACC_IDLE;
            phase_cnt   <= '0;
            wr_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (acc_state)
                ACC_IDLE: begin
                    if (bus.cmd_valid && cmd_ready) begin
                        wr_q      <= bus.cmd_write;
                        addr_q    <= bus.cmd_addr;
                        wdata_q   <= bus.cmd_wdata;
                        cs_n_q    <= 1'b0;
                        phase_cnt <= SETUP_LD;
                        acc_state <= ACC_SETUP;
                    end
                end
                ACC_SETUP: begin
                    if (phase_cnt == 4'd0) begin
                        rd_n_q    <= wr_q;
                        wr_n_q    <= ~wr_q;
                        phase_cnt <= STROBE_LD;
                        acc_state <= ACC_STROBE;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                ACC_STROBE: begin
                    if (phase_cnt == 4'd0) begin
                        rd_n_q      <= 1'b1;
                        wr_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        if (!wr_q) rdata_q <= bus.s_readdata;
                        phase_cnt   <= HOLD_LD;
                        acc_state   <= ACC_HOLD;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                ACC_HOLD: begin
                    if (phase_cnt == 4'd0) begin
                        cs_n_q    <= 1'b1;
                        phase_cnt <= RECOVER_LD;
                        acc_state <= ACC_RECOVER;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                ACC_RECOVER: begin
                    if (phase_cnt == 4'd0) acc_state <= ACC_IDLE;
                    else                   phase_cnt <= phase_cnt - 4'd1;
                end
                default: acc_state <= ACC_IDLE;
            endcase
        end
    end

    // Controller power-on reset: hold low, then let it settle before accepting commands.
    always_ff @(posedge s_clk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            init_state  <= INIT_RST_LOW;
            init_cnt    <= RST_LOW_LD;
            usb_rst_n_q <= 1'b0;
        end else begin
            case (init_state)
                INIT_RST_LOW: begin
                    if (init_cnt == 16'd0) begin
                        usb_rst_n_q <= 1'b1;
                        init_cnt    <= RST_WAIT_LD;
                        init_state  <= INIT_RST_WAIT;
                    end else begin
                        init_cnt <= init_cnt - 16'd1;
                    end
                end
                INIT_RST_WAIT: begin
                    if (init_cnt == 16'd0) init_state <= INIT_READY;
                    else                   init_cnt   <= init_cnt - 16'd1;
                end
                INIT_READY: init_state <= INIT_READY;
                default:    init_state <= INIT_RST_LOW;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.s_cs_n      = cs_n_q;
    assign bus.s_read_n    = rd_n_q;
    assign bus.s_write_n   = wr_n_q;
    assign bus.s_address   = addr_q;
    assign bus.s_writedata = wdata_q;
    assign usb_reset_n     = usb_rst_n_q;

    isp1761_irq_sync u_irq_sync (
        .clk       (s_clk),
        .rst_n     (s_reset_n),
        .irq_async (s_irq),
        .irq_level (irq_level),
        .irq_pulse (irq_pulse)
    );
endmodule
